// File: rtl/sonar_scheduler.sv
// Round-robin ping scheduler for HC-SR04 rangers sharing one timing datapath.
// Triggers each enabled sensor in turn, times its echo and hands results out over valid/ready.
module sonar_scheduler #(
  parameter int unsigned N_SENSORS      = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned CNT_W          = 22,
  parameter int unsigned TRIG_CYCLES    = 550,
  parameter int unsigned TIMEOUT_CYCLES = 1_900_000,
  parameter int unsigned GUARD_CYCLES   = 3_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N_SENSORS-1:0] sensor_mask,
  input  logic [N_SENSORS-1:0] echo,
  output logic [N_SENSORS-1:0] trigger,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ID_W-1:0]      res_id,
  output logic [CNT_W-1:0]     res_cycles,
  output logic                 res_timeout,
  output logic                 busy
);

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StMeas,
    StReport,
    StGuard
  } state_e;

  localparam logic [CNT_W-1:0] TrigLast    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutVal  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] GuardLast   = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [ID_W-1:0]  PtrInit     = ID_W'(N_SENSORS - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [ID_W-1:0]        next_sel;
  logic                   echo_q, echo_sel;
  logic [N_SENSORS-1:0]   trigger_q, trigger_d;
  logic                   res_valid_q, res_valid_d;
  logic [ID_W-1:0]        res_id_q, res_id_d;
  logic [CNT_W-1:0]       res_cycles_q, res_cycles_d;
  logic                   res_timeout_q, res_timeout_d;

  assign echo_sel = echo[ptr_q];

  // Next set mask bit after ptr, cyclic: lowest index above ptr wins, else lowest at/below it.
  always_comb begin
    next_sel = ptr_q;
    for (int j = int'(N_SENSORS) - 1; j >= 0; j--) begin
      if (sensor_mask[j] && j <= int'(ptr_q)) next_sel = ID_W'(j);
    end
    for (int j = int'(N_SENSORS) - 1; j >= 0; j--) begin
      if (sensor_mask[j] && j > int'(ptr_q)) next_sel = ID_W'(j);
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 1'b1;
    ptr_d         = ptr_q;
    res_valid_d   = res_valid_q;
    res_id_d      = res_id_q;
    res_cycles_d  = res_cycles_q;
    res_timeout_d = res_timeout_q;

    unique case (state_q)
      StIdle: begin
        if (en && |sensor_mask) begin
          ptr_d   = next_sel;
          state_d = StTrig;
        end
      end
      StTrig: begin
        if (cnt_q == TrigLast) state_d = StWaitRise;
      end
      StWaitRise: begin
        if (echo_sel && !echo_q) begin
          state_d = StMeas;
        end else if (cnt_q == TimeoutLast) begin
          state_d       = StReport;
          res_valid_d   = 1'b1;
          res_id_d      = ptr_q;
          res_cycles_d  = TimeoutVal;
          res_timeout_d = 1'b1;
        end
      end
      StMeas: begin
        if (!echo_sel) begin
          state_d       = StReport;
          res_valid_d   = 1'b1;
          res_id_d      = ptr_q;
          res_cycles_d  = cnt_q;
          res_timeout_d = 1'b0;
        end else if (cnt_q == TimeoutLast) begin
          state_d       = StReport;
          res_valid_d   = 1'b1;
          res_id_d      = ptr_q;
          res_cycles_d  = TimeoutVal;
          res_timeout_d = 1'b1;
        end
      end
      StReport: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StGuard;
        end
      end
      StGuard: begin
        if (cnt_q == GuardLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Shared counter restarts on every state entry; the rise cycle already counts as echo-high.
    if (state_d != state_q) begin
      cnt_d = (state_d == StMeas) ? CNT_W'(1) : '0;
    end else if (state_q == StIdle || state_q == StReport) begin
      cnt_d = '0;
    end

    trigger_d = '0;
    if (state_d == StTrig) trigger_d[ptr_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      ptr_q         <= PtrInit;
      echo_q        <= 1'b0;
      trigger_q     <= '0;
      res_valid_q   <= 1'b0;
      res_id_q      <= '0;
      res_cycles_q  <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      echo_q        <= echo_sel;
      trigger_q     <= trigger_d;
      res_valid_q   <= res_valid_d;
      res_id_q      <= res_id_d;
      res_cycles_q  <= res_cycles_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign trigger     = trigger_q;
  assign res_valid   = res_valid_q;
  assign res_id      = res_id_q;
  assign res_cycles  = res_cycles_q;
  assign res_timeout = res_timeout_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_sonar_scheduler.sv
// Scoreboard bench for sonar_scheduler: directed pings push expected results,
// an independent monitor pops and compares on every accepted result.
module tb_sonar_scheduler;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [N-1:0]  sensor_mask;
  logic [N-1:0]  echo;
  logic [N-1:0]  trigger;
  logic          res_valid;
  logic          res_ready;
  logic [1:0]    res_id;
  logic [21:0]   res_cycles;
  logic          res_timeout;
  logic          busy;

  typedef struct packed {
    logic [1:0]  id;
    logic [21:0] cycles;
    logic        to;
  } res_t;

  res_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_start = 0;

  sonar_scheduler #(
    .N_SENSORS(4),
    .ID_W(2),
    .CNT_W(22),
    .TRIG_CYCLES(4),
    .TIMEOUT_CYCLES(100),
    .GUARD_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .sensor_mask(sensor_mask),
    .echo(echo),
    .trigger(trigger),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_id(res_id),
    .res_cycles(res_cycles),
    .res_timeout(res_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every accepted result must match the head of the expected queue.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("res_id", res_id, e.id);
          chk("res_cycles", res_cycles, e.cycles);
          chk("res_timeout", res_timeout, e.to);
        end
      end
    end
  end

  // One ping on sensor id; width 0 means no echo at all.
  task automatic ping(input int id, input int delay, input int width, input bit stuck,
                      input bit stop, input int hold, input int exp_cyc, input bit exp_to,
                      input int exp_lat, input int exp_gap);
    int   n;
    int   hi;
    int   lat;
    int   bad;
    res_t e;
    logic [N-1:0] exp_trig;
    exp_trig = '0;
    exp_trig[id] = 1'b1;
    if (stuck) echo[id] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (trigger == '0 && n < 1000);
    if (trigger == '0) begin
      chk("trigger_start_timeout", 0, 1);
      return;
    end
    if (exp_gap > 0) chk("trigger_spacing", cyc - last_start, exp_gap);
    last_start = cyc;
    chk("trigger_onehot", trigger, exp_trig);
    if (stop) en = 1'b0;
    if (hold > 0) res_ready = 1'b0;
    e.id = 2'(id);
    e.cycles = 22'(exp_cyc);
    e.to = exp_to;
    exp_q.push_back(e);
    hi = 1;
    while (hi < 1000) begin
      @(negedge clk);
      if (trigger != exp_trig) break;
      hi++;
    end
    chk("trigger_width", hi, 4);
    fork
      begin
        if (width > 0) begin
          repeat (delay) @(posedge clk);
          #1 echo[id] = 1'b1;
          repeat (width) @(posedge clk);
          #1 echo[id] = 1'b0;
        end
      end
      begin
        lat = 0;
        while (!res_valid && lat < 1000) begin
          @(negedge clk);
          lat++;
        end
        chk("result_latency", lat, exp_lat);
        if (hold > 0) begin
          e.id = res_id;
          e.cycles = res_cycles;
          e.to = res_timeout;
          bad = 0;
          for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!res_valid || res_id != e.id || res_cycles != e.cycles || res_timeout != e.to)
              bad++;
          end
          chk("hold_stable", bad, 0);
          @(posedge clk);
          #1 res_ready = 1'b1;
        end
        @(posedge clk);
        #1;
      end
    join
    if (stuck) echo[id] = 1'b0;
  endtask

  initial begin
    int n;
    int trig_seen;
    rst = 1'b1;
    en = 1'b0;
    sensor_mask = '0;
    echo = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_trigger", trigger, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_id", res_id, 0);
    chk("rst_cycles", res_cycles, 0);
    chk("rst_timeout", res_timeout, 0);
    chk("rst_busy", busy, 0);

    // Empty mask never leaves idle.
    @(posedge clk);
    #1 rst = 1'b0;
    en = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("empty_mask_busy", busy, 0);

    @(posedge clk);
    #1 sensor_mask = 4'b1111;
    ping(0, 5, 30, 0, 0, 0, 30, 0, 36, 0);
    ping(1, 3, 1, 0, 0, 0, 1, 0, 5, 62);
    ping(2, 0, 0, 0, 0, 0, 100, 1, 100, 31);
    ping(3, 0, 0, 1, 0, 0, 100, 1, 100, 126);
    ping(0, 2, 150, 0, 1, 0, 100, 1, 102, 126);
    @(negedge clk);
    chk("stopped_busy", busy, 0);

    // Mask with two sensors alternates, and a stalled consumer stretches the spacing.
    @(posedge clk);
    #1 sensor_mask = 4'b1010;
    en = 1'b1;
    ping(1, 5, 10, 0, 0, 0, 10, 0, 16, 0);
    ping(3, 5, 10, 0, 0, 0, 10, 0, 16, 42);
    ping(1, 5, 10, 0, 0, 49, 10, 0, 16, 42);
    ping(3, 5, 10, 0, 0, 0, 10, 0, 16, 92);

    // Reset in the middle of sensor 1's measurement discards it.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (trigger == '0 && n < 1000);
    chk("pre_rst_trigger", trigger, 4'b0010);
    n = 0;
    while (trigger != '0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1 echo[1] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("meas_busy", busy, 1);
    #1 rst = 1'b1;
    sensor_mask = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_trigger", trigger, 0);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cycles", res_cycles, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    echo[1] = 1'b0;
    ping(0, 4, 20, 0, 1, 0, 20, 0, 25, 0);

    trig_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (trigger != '0) trig_seen++;
    end
    chk("stopped_no_trigger", trig_seen, 0);
    chk("final_busy", busy, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
